// File: rtl/mipi_stream_bringup_seq.sv
// Bring-up and recovery sequencer for the MIPI camera/audio path on the oscillator clock:
// holds the DPHY in reset, qualifies pixel-PLL lock, gates the streams and restarts on failure.
module mipi_stream_bringup_seq #(
  parameter int unsigned RST_LOW_CYCLES       = 14_400_000,
  parameter int unsigned LOCK_STABLE_CYCLES   = 4800,
  parameter int unsigned LOCK_TIMEOUT_CYCLES  = 480_000,
  parameter int unsigned FRAME_TIMEOUT_CYCLES = 9_600_000,
  parameter int unsigned MAX_RETRIES          = 3
) (
  input  logic       clk_osc,
  input  logic       reset_n_HFCLKOUT,
  input  logic       cam_app_en_i,
  input  logic       aud_app_en_i,
  input  logic       pll_lock_i,
  input  logic       cam_fv_i,
  output logic       mipi_reset_n_o,
  output logic       cam_stream_en_o,
  output logic       aud_stream_en_o,
  output logic       fault_o,
  output logic [2:0] state_o,
  output logic [3:0] retry_cnt_o,
  output logic [7:0] restart_total_o
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    MIPI_RST   = 3'd1,
    WAIT_LOCK  = 3'd2,
    WAIT_FRAME = 3'd3,
    STREAM     = 3'd4,
    FAULT      = 3'd5
  } state_e;

  // Timers load N-1 and act when they read 0, so each visit lasts exactly N cycles.
  localparam logic [31:0] RST_LOAD    = 32'(RST_LOW_CYCLES - 1);
  localparam logic [31:0] LOCK_LOAD   = 32'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [31:0] FRAME_LOAD  = 32'(FRAME_TIMEOUT_CYCLES - 1);
  localparam logic [31:0] LOCK_STABLE = 32'(LOCK_STABLE_CYCLES);
  localparam logic [3:0]  RETRY_LIMIT = 4'(MAX_RETRIES);

  // Synchronizer bit order: {fv, lock, aud, cam}.
  logic [3:0] sync1_q, sync2_q;
  logic       fv_dly_q;
  logic       cam_en_s, aud_en_s, lock_s, fv_s, fv_rise, any_en;

  always_ff @(posedge clk_osc or negedge reset_n_HFCLKOUT) begin
    if (!reset_n_HFCLKOUT) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      fv_dly_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make each stage sample the previous stage's old value.
      sync1_q  <= {cam_fv_i, pll_lock_i, aud_app_en_i, cam_app_en_i};
      sync2_q  <= sync1_q;
      fv_dly_q <= sync2_q[3];
    end
  end

  assign cam_en_s = sync2_q[0];
  assign aud_en_s = sync2_q[1];
  assign lock_s   = sync2_q[2];
  assign fv_s     = sync2_q[3];
  assign fv_rise  = fv_s & ~fv_dly_q;
  assign any_en   = cam_en_s | aud_en_s;

  state_e      state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] stable_q, stable_d;
  logic [3:0]  retry_q, retry_d;
  logic [7:0]  total_q, total_d;
  logic        timer_zero, do_retry;
  logic        mipi_reset_n_q, cam_stream_en_q, aud_stream_en_q, fault_q;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    timer_zero = (timer_q == '0);
    timer_d    = timer_zero ? '0 : timer_q - 32'd1;
    stable_d   = '0;
    retry_d    = retry_q;
    total_d    = total_q;
    do_retry   = 1'b0;

    if (state_q != IDLE && !any_en) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          retry_d = '0;
          if (any_en) begin
            state_d = MIPI_RST;
            timer_d = RST_LOAD;
          end
        end
        MIPI_RST: begin
          if (timer_zero) begin
            state_d = WAIT_LOCK;
            timer_d = LOCK_LOAD;
          end
        end
        WAIT_LOCK: begin
          stable_d = lock_s ? stable_q + 32'd1 : '0;
          if (timer_zero) begin
            do_retry = 1'b1;
          end else if (lock_s && (stable_q + 32'd1 == LOCK_STABLE)) begin
            state_d = WAIT_FRAME;
            timer_d = FRAME_LOAD;
          end
        end
        WAIT_FRAME: begin
          // An FV edge on the expiry cycle counts as progress, not a timeout.
          if (!lock_s || (cam_en_s && timer_zero && !fv_rise)) begin
            do_retry = 1'b1;
          end else if (!cam_en_s || fv_rise) begin
            state_d = STREAM;
            timer_d = FRAME_LOAD;
            retry_d = '0;
          end
        end
        STREAM: begin
          // The frame watchdog only runs while the camera is enabled.
          if (!lock_s || (cam_en_s && timer_zero && !fv_rise)) begin
            do_retry = 1'b1;
          end else if (!cam_en_s || fv_rise) begin
            timer_d = FRAME_LOAD;
          end
        end
        FAULT:   state_d = FAULT;
        default: state_d = IDLE;
      endcase

      if (do_retry) begin
        if (retry_q == RETRY_LIMIT) begin
          state_d = FAULT;
        end else begin
          retry_d = retry_q + 4'd1;
          total_d = (total_q == 8'hFF) ? total_q : total_q + 8'd1;
          state_d = MIPI_RST;
          timer_d = RST_LOAD;
        end
      end
    end
  end

  always_ff @(posedge clk_osc or negedge reset_n_HFCLKOUT) begin
    if (!reset_n_HFCLKOUT) begin
      state_q         <= IDLE;
      timer_q         <= '0;
      stable_q        <= '0;
      retry_q         <= '0;
      total_q         <= '0;
      mipi_reset_n_q  <= 1'b0;
      cam_stream_en_q <= 1'b0;
      aud_stream_en_q <= 1'b0;
      fault_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      stable_q        <= stable_d;
      retry_q         <= retry_d;
      total_q         <= total_d;
      mipi_reset_n_q  <= state_d inside {WAIT_LOCK, WAIT_FRAME, STREAM};
      cam_stream_en_q <= (state_d == STREAM) && cam_en_s;
      aud_stream_en_q <= (state_d inside {WAIT_FRAME, STREAM}) && aud_en_s;
      fault_q         <= (state_d == FAULT);
    end
  end

  assign state_o         = state_q;
  assign retry_cnt_o     = retry_q;
  assign restart_total_o = total_q;
  assign mipi_reset_n_o  = mipi_reset_n_q;
  assign cam_stream_en_o = cam_stream_en_q;
  assign aud_stream_en_o = aud_stream_en_q;
  assign fault_o         = fault_q;

endmodule

// File: doc/mipi_stream_bringup_seq.md
# mipi_stream_bringup_seq

Bring-up and recovery sequencer for the MIPI camera/audio streaming path, running on the internal oscillator domain. It holds the MIPI DPHY receiver in reset for a fixed time, waits for the pixel PLL (fed by the MIPI byte clock) to lock stably, and then enables the camera and audio streams. It watches frame activity and, on loss of lock or frame timeout, automatically re-runs the sequence. It drives `mipidphy2cmos.reset_n_i` and gates the stream enables used by the video and audio buffer resets.

## Interface
Parameters:
- `RST_LOW_CYCLES`, 14_400_000 — `mipi_reset_n_o` low time in MIPI_RST (300 ms at 48 MHz).
- `LOCK_STABLE_CYCLES`, 4800 — consecutive synchronized lock-high cycles required (100 µs).
- `LOCK_TIMEOUT_CYCLES`, 480_000 — maximum WAIT_LOCK dwell (10 ms).
- `FRAME_TIMEOUT_CYCLES`, 9_600_000 — maximum gap between FV rising edges (200 ms).
- `MAX_RETRIES`, 3 — consecutive restarts before FAULT; range 1..15.

Ports:
- `clk_osc` in 1 — 48 MHz oscillator clock.
- `reset_n_HFCLKOUT` in 1 — reset; asynchronous, active-low.
- `cam_app_en_i` in 1 — camera application enable; asynchronous.
- `aud_app_en_i` in 1 — audio application enable; asynchronous.
- `pll_lock_i` in 1 — pixel PLL lock; asynchronous.
- `cam_fv_i` in 1 — frame valid from the pixel domain; asynchronous level.
- `mipi_reset_n_o` out 1 — MIPI DPHY reset, active-low.
- `cam_stream_en_o` out 1 — camera stream enable.
- `aud_stream_en_o` out 1 — audio stream enable.
- `fault_o` out 1 — retries exhausted.
- `state_o` out 3 — current state encoding.
- `retry_cnt_o` out 4 — consecutive retries.
- `restart_total_o` out 8 — total restarts since reset; saturates at 255.

## Operation
- All four asynchronous inputs pass through 2-FF synchronizers.
- FV rising edge is detected from synchronizer stage 2 and a one-cycle delayed copy.
- A single 32-bit down-counter serves as the state timer. A separate 32-bit counter serves as the lock-stable counter.
- `any_en` = cam_en_s | aud_en_s.
- States:
  - IDLE=0: enter MIPI_RST when `any_en` is high; retry_cnt is set to 0.
  - MIPI_RST=1: stay exactly RST_LOW_CYCLES cycles, then go to WAIT_LOCK.
  - WAIT_LOCK=2: any lock_s low cycle clears the stable count. When the stable count reaches LOCK_STABLE_CYCLES, go to WAIT_FRAME. If LOCK_TIMEOUT_CYCLES elapses first, RETRY.
  - WAIT_FRAME=3:
    - If cam_en_s is low, go to STREAM immediately.
    - Otherwise, an FV rising edge goes to STREAM.
    - FRAME_TIMEOUT_CYCLES elapsed triggers RETRY.
    - lock_s low triggers RETRY.
  - STREAM=4:
    - Entering STREAM sets retry_cnt to 0.
    - Each FV edge reloads the frame timer.
    - Timer expiry triggers RETRY, but only when cam_en_s is high.
    - lock_s low triggers RETRY.
  - FAULT=5: hold here until `any_en` is low, then go to IDLE.
- RETRY is an action, not a state:
  - If retry_cnt == MAX_RETRIES, go to FAULT.
  - Otherwise retry_cnt increments, restart_total increments (saturating), and the FSM goes to MIPI_RST with the timer reloaded.
- Priority, highest first:
  1. `any_en` low in any state except IDLE → IDLE.
  2. RETRY.
  3. Normal progress.
- A timeout and an FV edge in the same cycle: the FV edge wins (progress/reload).
- Output decoding (all registered, derived from next state):
  - `mipi_reset_n_o` = 1 in WAIT_LOCK, WAIT_FRAME and STREAM; 0 otherwise.
  - `cam_stream_en_o` = STREAM & cam_en_s.
  - `aud_stream_en_o` = (WAIT_FRAME | STREAM) & aud_en_s.
  - `fault_o` = FAULT.
- Reset values:
  - `state_o`=0, `mipi_reset_n_o`=0, all enables 0, `fault_o`=0.
  - All counters 0; synchronizers 0.

## Timing
- Asynchronous input change to FSM reaction: the FSM registers on the 3rd rising edge after the input meets setup (2 synchronizer edges plus 1 FSM edge). Outputs update on that same edge.
- `mipi_reset_n_o` is low for exactly RST_LOW_CYCLES cycles per MIPI_RST visit. It rises on the same edge that `state_o` becomes 2.
- Lock qualification: WAIT_FRAME is entered on the edge where the LOCK_STABLE_CYCLES-th consecutive high lock_s sample is counted.
- Timeouts fire on the edge where the timer reaches 0. For example, a WAIT_LOCK visit lasts LOCK_TIMEOUT_CYCLES cycles.
- `cam_stream_en_o` deasserts on the edge where the FSM leaves STREAM. There is no extra lag.
- Removing both enables mid-MIPI_RST aborts to IDLE. A later enable restarts the full RST_LOW_CYCLES period.

## Test plan
All tests use parameters RST_LOW_CYCLES=16, LOCK_STABLE_CYCLES=4, LOCK_TIMEOUT_CYCLES=64, FRAME_TIMEOUT_CYCLES=256, MAX_RETRIES=2.
- **Nominal bring-up.** Stimulus: cam_en=1, aud_en=1, lock high, FV every 100 cycles. Required: mipi_reset_n_o low 16 cycles then high; state 2→3 after 4 lock cycles; STREAM on the first FV edge; cam and aud enables =1; retry_cnt=0.
- **Lock glitch.** Stimulus: drop lock for 1 cycle during WAIT_LOCK. Required: stable count restarts and WAIT_FRAME entry is delayed by the glitch. Stimulus: drop lock for 3 cycles in STREAM. Required: RETRY → MIPI_RST, restart_total=1, cam_stream_en_o=0.
- **Lock never asserts.** Required: three WAIT_LOCK timeouts of 64 cycles each; retry_cnt 1, 2, then FAULT; fault_o=1; mipi_reset_n_o=0. Then drop both enables: IDLE and fault_o=0.
- **Audio only.** Stimulus: cam_en=0, aud_en=1, no FV. Required: STREAM reached directly from WAIT_FRAME; aud_stream_en_o=1; cam_stream_en_o=0; no frame timeout after 1000 cycles.
- **Frame stall.** Stimulus: stop FV in STREAM. Required: RETRY exactly 256 cycles after the last FV edge. When FV resumes, STREAM is re-entered and retry_cnt returns to 0.
- **Simultaneous events and reset.** Stimulus: FV edge coincides with timer=0. Required: STREAM kept and timer reloaded. Stimulus: assert reset_n_HFCLKOUT low mid-STREAM. Required: all outputs 0 immediately, asynchronously.
